cclut_cfeb_sort_scheduler: RTL and testbench
============================================

CCLUT_CFEB_SORT_SCHEDULER -- requirements
Module: cclut_cfeb_sort_scheduler

Interface
REQ-001 Parameters SHALL be: MXCFEB 7, number of CFEBs; MXPATB 7, pattern bits; MXKEYB 5, 1/2-strip key bits per CFEB; MXPATC 11, ccLUT carry bits; MXKEYBX 8, chamber 1/2-strip key bits; SORT_LAT 1, clocks from sel_cfeb to sort_* result.
REQ-002 Ports SHALL be:
- clock in 1: sole clock, rising edge.
- reset in 1: asynchronous, active-high.
- start in 1: sort request pulse.
- cfeb_en in MXCFEB: CFEBs to sort, sampled with start.
- pat_thresh in 6: minimum pattern[6:1], sampled with start.
- sort_pat in MXPATB: best pattern returned by the shared 1-of-32 sorter.
- sort_key in MXKEYB: key returned by the sorter.
- sort_carry in MXPATC: carry returned by the sorter.
- sel_cfeb out 3: CFEB routed into the shared sorter.
- sel_vld out 1: sel_cfeb is a live issue.
- busy out 1: sort in progress.
- done out 1: one-clock result strobe.
- best_vld out 1: a qualifying pattern was found.
- best_pat out MXPATB: winning pattern.
- best_key out MXKEYBX: chamber key, cfeb*32+key.
- best_carry out MXPATC: winning carry.

Function
REQ-003 The block SHALL time-share one shared best-1-of-32 sorter across MXCFEB CFEBs using states IDLE, ISSUE, DRAIN, DONE.
REQ-004 In IDLE, a clock edge with start=1 SHALL latch cfeb_en and pat_thresh, clear the running best, and go to ISSUE; if the latched mask is zero, the block SHALL go directly to DONE instead.
REQ-005 ISSUE SHALL drive sel_vld=1 with sel_cfeb set to each enabled CFEB in ascending order, one per clock, and SHALL skip disabled CFEBs with no idle cycles.
REQ-006 After the last enabled CFEB is issued, the block SHALL go to DRAIN for SORT_LAT clocks, then to DONE.
REQ-007 A sel_vld/sel_cfeb pair SHALL be delayed SORT_LAT clocks internally; sort_* SHALL be sampled only when the delayed valid is 1, and tagged with the delayed cfeb.
REQ-008 A sampled result SHALL qualify only if sort_pat[6:1] >= pat_thresh.
REQ-009 A qualifying result SHALL replace the running best only if no best is held yet, or if sort_pat[6:1] is strictly greater than the held pat[6:1]; on ties the lower CFEB SHALL win.
REQ-010 best_key SHALL be {sel_cfeb_delayed, sort_key}; the width is 8 bits, the range is 0..223, and the value SHALL never wrap.
REQ-011 DONE SHALL last exactly one clock, SHALL assert done=1, SHALL present the registered best_* outputs, and SHALL return to IDLE.
REQ-012 best_* SHALL hold their values until the next done.
REQ-013 For k enabled CFEBs with start sampled at edge t:
- sel_vld is high during cycles t+1..t+k.
- done is high during cycle t+k+SORT_LAT+1.
- For k=0, done is high during cycle t+1.
REQ-014 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored while busy=1, including in the DONE cycle; no request queueing.
REQ-016 If no result qualifies, done SHALL still pulse, with best_vld=0 and best_pat, best_key, best_carry all 0.
REQ-017 sel_cfeb SHALL be 0 whenever sel_vld=0.

Reset
REQ-018 reset=1 SHALL force IDLE immediately, independent of clock, including mid-sort.
REQ-019 While reset=1, every output SHALL be 0 and the internal delay line and running best SHALL be cleared.
REQ-020 A sort interrupted by reset SHALL produce no done pulse.
REQ-021 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-022 MXCFEB, MXPATB, MXKEYB, MXPATC, MXKEYBX and SORT_LAT SHALL live in the shared pattern-finder constants package, alongside the best-of-32 sorter's constants.
REQ-023 The state encoding SHALL be a package-level enumerated type.
REQ-024 A single sub-module, cfeb_issue_delay, SHALL implement the SORT_LAT-deep delay of {sel_vld, sel_cfeb}.
REQ-025 The sorter input mux and the sorter itself SHALL be outside this block.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Full sort: cfeb_en=7'h7F, thresh 0, sorter model returns pat[6:1]=cfeb index, key=5 -> sel_cfeb 0..6 on 7 consecutive clocks, done at t+9, best_pat[6:1]=6, best_key=8'd197.
- Tie: cfeb_en=7'b0010100, both results pat=7'h50, keys 3 and 9 -> best_key=8'd67 (CFEB2); sel_vld high exactly 2 clocks; done at t+4.
- Threshold: thresh 6'd40, all returned pat[6:1]=39 -> done=1, best_vld=0, all best_* outputs 0.
- Empty mask: cfeb_en=0 -> done at t+1; sel_vld never asserted.
- Busy rejection: start re-pulsed at t+3 and in the DONE cycle -> exactly one done, and busy drops to 0 the clock after done.
- Reset mid-ISSUE: reset asserted at t+3 with no clock edge -> outputs 0 immediately, no done; next start completes normally.

Source files
------------

// File: rtl/cclut_cfeb_sort_scheduler_pkg.sv
// Shared pattern-finder constants for the ccLUT CFEB sort path.
// Holds the chamber and CFEB geometry, the constants of the shared best-1-of-32 sorter,
// the scheduler state type and a small priority-encode helper.
package cclut_cfeb_sort_scheduler_pkg;

  // Best-of-32 sorter geometry: one sorter sees the 32 1/2-strip keys of a single CFEB.
  localparam int unsigned MXSORTIN = 32;

  localparam int unsigned MXCFEB   = 7;                  // number of CFEBs
  localparam int unsigned MXPATB   = 7;                  // pattern bits
  localparam int unsigned MXKEYB   = $clog2(MXSORTIN);   // 1/2-strip key bits per CFEB (5)
  localparam int unsigned MXPATC   = 11;                 // ccLUT carry bits
  localparam int unsigned MXKEYBX  = 8;                  // chamber 1/2-strip key bits
  localparam int unsigned SORT_LAT = 1;                  // clocks from sel_cfeb to sort_* result

  localparam int unsigned CFEB_IDX_W = 3;                // width of a CFEB index

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

  // Index of the lowest set bit of a CFEB mask; 0 for an empty mask.
  function automatic logic [CFEB_IDX_W-1:0] first_set_cfeb(input logic [MXCFEB-1:0] mask);
    logic [CFEB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MXCFEB - 1; i >= 0; i--) begin
      if (mask[i]) idx = CFEB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cfeb_issue_delay.sv
// Delay line matching the latency of the shared sorter.
// Carries the {valid, cfeb} tag of each issue so a returning sorter result can be
// attributed to the CFEB that produced it.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   in_vld/in_cfeb   : issue tag entering the sorter
//   out_vld/out_cfeb : same tag, SortLat clocks later
module cfeb_issue_delay #(
  parameter int unsigned SortLat = 1,
  parameter int unsigned IdxW    = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_vld,
  input  logic [IdxW-1:0] in_cfeb,
  output logic            out_vld,
  output logic [IdxW-1:0] out_cfeb
);

  logic [SortLat-1:0]           vld_q;
  logic [SortLat-1:0][IdxW-1:0] cfeb_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      cfeb_q <= '0;
    end else begin
      vld_q[0]  <= in_vld;
      cfeb_q[0] <= in_cfeb;
      for (int i = 1; i < int'(SortLat); i++) begin
        vld_q[i]  <= vld_q[i-1];
        cfeb_q[i] <= cfeb_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[SortLat-1];
  assign out_cfeb = cfeb_q[SortLat-1];

endmodule

// File: rtl/cclut_cfeb_sort_scheduler.sv
// Time-shares one external best-1-of-32 sorter across all CFEBs.
// On start, each enabled CFEB is routed into the sorter in ascending order, one per clock.
// Returning results are tagged through cfeb_issue_delay, threshold-qualified, and the
// best one (highest pattern[6:1], lower CFEB on ties) is presented with a one-clock done.
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   start, cfeb_en, pat_thresh : sort request, CFEB mask and minimum pattern[6:1]
//   sort_pat/key/carry : result returned by the shared sorter SORT_LAT clocks after issue
//   sel_cfeb, sel_vld  : CFEB currently routed into the sorter
//   busy, done         : sort in progress, one-clock result strobe
//   best_vld/pat/key/carry : registered winner, held until the next done
module cclut_cfeb_sort_scheduler
  import cclut_cfeb_sort_scheduler_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MXCFEB-1:0]     cfeb_en,
  input  logic [5:0]            pat_thresh,
  input  logic [MXPATB-1:0]     sort_pat,
  input  logic [MXKEYB-1:0]     sort_key,
  input  logic [MXPATC-1:0]     sort_carry,
  output logic [CFEB_IDX_W-1:0] sel_cfeb,
  output logic                  sel_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  best_vld,
  output logic [MXPATB-1:0]     best_pat,
  output logic [MXKEYBX-1:0]    best_key,
  output logic [MXPATC-1:0]     best_carry
);

  localparam int unsigned DRAIN_W = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(SORT_LAT - 1);

  sched_state_e        state_q, state_d;
  logic [MXCFEB-1:0]   pend_q, pend_d;      // enabled CFEBs not yet issued
  logic [5:0]          thresh_q, thresh_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;

  logic                run_vld_q, run_vld_d;
  logic [MXPATB-1:0]   run_pat_q, run_pat_d;
  logic [MXKEYBX-1:0]  run_key_q, run_key_d;
  logic [MXPATC-1:0]   run_carry_q, run_carry_d;

  logic                  dly_vld;
  logic [CFEB_IDX_W-1:0] dly_cfeb;
  logic                  res_qual;
  logic                  res_better;

  assign sel_vld  = (state_q == StIssue) && (|pend_q);
  assign sel_cfeb = sel_vld ? first_set_cfeb(pend_q) : '0;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  cfeb_issue_delay #(
    .SortLat (SORT_LAT),
    .IdxW    (CFEB_IDX_W)
  ) u_issue_delay (
    .clock    (clock),
    .reset    (reset),
    .in_vld   (sel_vld),
    .in_cfeb  (sel_cfeb),
    .out_vld  (dly_vld),
    .out_cfeb (dly_cfeb)
  );

  // Issue order is ascending, so strict greater-than leaves ties with the lower CFEB.
  assign res_qual   = dly_vld && (sort_pat[MXPATB-1:1] >= thresh_q);
  assign res_better = !run_vld_q || (sort_pat[MXPATB-1:1] > run_pat_q[MXPATB-1:1]);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    thresh_d    = thresh_q;
    drain_d     = drain_q;
    run_vld_d   = run_vld_q;
    run_pat_d   = run_pat_q;
    run_key_d   = run_key_q;
    run_carry_d = run_carry_q;

    if (res_qual && res_better) begin
      run_vld_d   = 1'b1;
      run_pat_d   = sort_pat;
      run_key_d   = {dly_cfeb, sort_key};
      run_carry_d = sort_carry;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pend_d      = cfeb_en;
          thresh_d    = pat_thresh;
          run_vld_d   = 1'b0;
          run_pat_d   = '0;
          run_key_d   = '0;
          run_carry_d = '0;
          state_d     = (|cfeb_en) ? StIssue : StDone;
        end
      end
      StIssue: begin
        // Clear the lowest set bit: the CFEB being issued this clock.
        pend_d = pend_q & (pend_q - MXCFEB'(1));
        if (pend_d == '0) begin
          state_d = StDrain;
          drain_d = DRAIN_INIT;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      thresh_q    <= '0;
      drain_q     <= '0;
      run_vld_q   <= 1'b0;
      run_pat_q   <= '0;
      run_key_q   <= '0;
      run_carry_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      thresh_q    <= thresh_d;
      drain_q     <= drain_d;
      run_vld_q   <= run_vld_d;
      run_pat_q   <= run_pat_d;
      run_key_q   <= run_key_d;
      run_carry_q <= run_carry_d;
    end
  end

  // Output registers load from the next-state best so the final drained result is
  // included and the winner is visible in the done cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_vld   <= 1'b0;
      best_pat   <= '0;
      best_key   <= '0;
      best_carry <= '0;
    end else if (state_d == StDone) begin
      best_vld   <= run_vld_d;
      best_pat   <= run_pat_d;
      best_key   <= run_key_d;
      best_carry <= run_carry_d;
    end
  end

endmodule

// File: tb/tb_cclut_cfeb_sort_scheduler.sv
// Directed bench for cclut_cfeb_sort_scheduler with a latency-1 sorter model driven
// from per-CFEB result tables.
module tb_cclut_cfeb_sort_scheduler;
  import cclut_cfeb_sort_scheduler_pkg::*;

  logic                  clock;
  logic                  reset;
  logic                  start;
  logic [MXCFEB-1:0]     cfeb_en;
  logic [5:0]            pat_thresh;
  logic [MXPATB-1:0]     sort_pat;
  logic [MXKEYB-1:0]     sort_key;
  logic [MXPATC-1:0]     sort_carry;
  logic [CFEB_IDX_W-1:0] sel_cfeb;
  logic                  sel_vld;
  logic                  busy;
  logic                  done;
  logic                  best_vld;
  logic [MXPATB-1:0]     best_pat;
  logic [MXKEYBX-1:0]    best_key;
  logic [MXPATC-1:0]     best_carry;

  int total = 0;
  int bad   = 0;

  logic [MXPATB-1:0] pat_tab   [8];
  logic [MXKEYB-1:0] key_tab   [8];
  logic [MXPATC-1:0] carry_tab [8];

  // Sorter model: result for the CFEB issued one clock earlier; junk when nothing issued.
  logic                  m_vld;
  logic [CFEB_IDX_W-1:0] m_cfeb;

  always_ff @(posedge clock) begin
    m_vld  <= sel_vld;
    m_cfeb <= sel_cfeb;
  end

  assign sort_pat   = m_vld ? pat_tab[m_cfeb]   : 7'h7E;
  assign sort_key   = m_vld ? key_tab[m_cfeb]   : 5'h1F;
  assign sort_carry = m_vld ? carry_tab[m_cfeb] : 11'h7FF;

  cclut_cfeb_sort_scheduler u_dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cfeb_en    (cfeb_en),
    .pat_thresh (pat_thresh),
    .sort_pat   (sort_pat),
    .sort_key   (sort_key),
    .sort_carry (sort_carry),
    .sel_cfeb   (sel_cfeb),
    .sel_vld    (sel_vld),
    .busy       (busy),
    .done       (done),
    .best_vld   (best_vld),
    .best_pat   (best_pat),
    .best_key   (best_key),
    .best_carry (best_carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel_vld"},  32'(sel_vld),    32'd0);
    chk({tag, "_sel_cfeb"}, 32'(sel_cfeb),   32'd0);
    chk({tag, "_busy"},     32'(busy),       32'd0);
    chk({tag, "_done"},     32'(done),       32'd0);
    chk({tag, "_bvld"},     32'(best_vld),   32'd0);
    chk({tag, "_bpat"},     32'(best_pat),   32'd0);
    chk({tag, "_bkey"},     32'(best_key),   32'd0);
    chk({tag, "_bcarry"},   32'(best_carry), 32'd0);
  endtask

  // Runs one sort. start_at bit c drives start=1 during cycle c after the accepting edge.
  task automatic run_sort(input string nm, input logic [6:0] mask, input logic [5:0] th,
                          input int done_cyc, input logic [31:0] start_at,
                          input logic ev, input logic [6:0] ep, input logic [7:0] ek,
                          input logic [10:0] ec);
    int order[$];
    for (int i = 0; i < 7; i++) if (mask[i]) order.push_back(i);
    cfeb_en    = mask;
    pat_thresh = th;
    start      = 1'b1;
    step();
    start      = 1'b0;
    // Scramble request inputs: they must have been latched.
    cfeb_en    = ~mask;
    pat_thresh = ~th;
    for (int c = 1; c <= done_cyc + 2; c++) begin
      start = start_at[c];
      chk({nm, "_sel_vld"},  32'(sel_vld),  (c <= order.size()) ? 32'd1 : 32'd0);
      chk({nm, "_sel_cfeb"}, 32'(sel_cfeb), (c <= order.size()) ? 32'(order[c-1]) : 32'd0);
      chk({nm, "_done"},     32'(done),     (c == done_cyc) ? 32'd1 : 32'd0);
      chk({nm, "_busy"},     32'(busy),     (c <= done_cyc) ? 32'd1 : 32'd0);
      if (c == done_cyc) begin
        chk({nm, "_best_vld"},   32'(best_vld),   32'(ev));
        chk({nm, "_best_pat"},   32'(best_pat),   32'(ep));
        chk({nm, "_best_key"},   32'(best_key),   32'(ek));
        chk({nm, "_best_carry"}, 32'(best_carry), 32'(ec));
      end
      step();
    end
    start = 1'b0;
    chk({nm, "_hold_key"},   32'(best_key),   32'(ek));
    chk({nm, "_hold_carry"}, 32'(best_carry), 32'(ec));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    cfeb_en    = '0;
    pat_thresh = '0;
    for (int i = 0; i < 8; i++) begin
      pat_tab[i]   = 7'(i << 1);       // pattern[6:1] = cfeb index
      key_tab[i]   = 5'd5;
      carry_tab[i] = 11'h100 + 11'(i);
    end

    #12;
    chk_all_zero("reset");
    step();
    reset = 1'b0;

    // Full sort: winner CFEB6, pat 7'h0C, key 6*32+5=197, carry 0x106, done at t+9.
    run_sort("full", 7'h7F, 6'd0, 9, 32'd0, 1'b1, 7'h0C, 8'd197, 11'h106);

    // Tie between CFEB2 and CFEB4: lower CFEB wins, key 2*32+3=67, done at t+4.
    for (int i = 0; i < 8; i++) pat_tab[i] = 7'h50;
    key_tab[2] = 5'd3;
    key_tab[4] = 5'd9;
    run_sort("tie", 7'b0010100, 6'd0, 4, 32'd0, 1'b1, 7'h50, 8'd67, 11'h102);

    // Empty mask: done at t+1, no issue, previous best cleared.
    run_sort("empty", 7'h00, 6'd0, 1, 32'd0, 1'b0, 7'h00, 8'd0, 11'h000);

    // Threshold 40 vs pattern[6:1]=39 (pattern[0] set must not help): nothing qualifies.
    for (int i = 0; i < 8; i++) pat_tab[i] = 7'h4F;
    run_sort("thresh", 7'h7F, 6'd40, 9, 32'd0, 1'b0, 7'h00, 8'd0, 11'h000);

    // Busy rejection: start re-pulsed in cycle 3 and in the done cycle (4).
    for (int i = 0; i < 8; i++) begin
      pat_tab[i] = 7'(i << 1);
      key_tab[i] = 5'd5;
    end
    run_sort("busy", 7'b1000001, 6'd0, 4, 32'h0000_0018, 1'b1, 7'h0C, 8'd197, 11'h106);
    for (int c = 0; c < 4; c++) begin
      chk("busy_after_done", 32'(done), 32'd0);
      chk("busy_after_vld",  32'(sel_vld), 32'd0);
      step();
    end

    // Reset mid-ISSUE, asserted between clock edges.
    cfeb_en    = 7'h7F;
    pat_thresh = 6'd0;
    start      = 1'b1;
    step();
    start      = 1'b0;
    step();
    step();
    chk("rstmid_pre_vld",  32'(sel_vld),  32'd1);
    chk("rstmid_pre_cfeb", 32'(sel_cfeb), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("rstmid");
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("rstmid_no_done", 32'(done), 32'd0);
      chk("rstmid_idle",    32'(busy), 32'd0);
      step();
    end

    // Normal sort after the interrupted one.
    run_sort("after_rst", 7'b0101010, 6'd2, 5, 32'd0, 1'b1, 7'h0A, 8'd165, 11'h105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
